// File: rtl/rv_pkg.sv
// Shared RV32 front-end definitions.
// Opcode map and fetch FSM encoding.
package rv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_OUT
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, imem req/gnt/rvalid handshake,
// valid/ready hand-off to decode, redirect with in-flight squash.
module instr_fetch_unit #(
  parameter int              XLEN      = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(rv_pkg::NOP_INSTR)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [6:0]      if_opcode,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            misalign_err,
  output logic [31:0]     fetch_count
);

  import rv_pkg::*;

  fetch_state_e    state, state_n;
  logic [XLEN-1:0] pc_q, pc_n;
  logic [XLEN-1:0] instr_q, instr_n;
  logic [XLEN-1:0] ipc_q, ipc_n;
  logic            valid_q, valid_n;
  logic            kill_q, kill_n;
  logic            mis_q, mis_n;
  logic [31:0]     cnt_q, cnt_n;
  logic [XLEN-1:0] tgt;

  assign tgt = {redirect_target[XLEN-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      kill_q  <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_n;
      pc_q    <= pc_n;
      instr_q <= instr_n;
      ipc_q   <= ipc_n;
      valid_q <= valid_n;
      kill_q  <= kill_n;
      mis_q   <= mis_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    instr_n = instr_q;
    ipc_n   = ipc_q;
    valid_n = valid_q;
    kill_n  = kill_q;
    mis_n   = 1'b0;
    cnt_n   = cnt_q;
    unique case (state)
      S_IDLE: state_n = S_FETCH;
      S_FETCH: begin
        if (imem_gnt) begin
          state_n = S_WAIT;
          kill_n  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          // response consumed either way; a coincident redirect drops it
          kill_n  = 1'b0;
          state_n = S_FETCH;
          if (!kill_q && !redirect_valid) begin
            instr_n = imem_rdata;
            ipc_n   = pc_q;
            valid_n = 1'b1;
            pc_n    = pc_q + XLEN'(4);
            state_n = S_OUT;
          end
        end else if (redirect_valid) begin
          kill_n = 1'b1;
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          valid_n = 1'b0;
          instr_n = NOP_INSTR;
          state_n = S_FETCH;
        end else if (id_ready) begin
          valid_n = 1'b0;
          instr_n = NOP_INSTR;
          cnt_n   = cnt_q + 32'd1;
          state_n = S_FETCH;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (redirect_valid) begin
      pc_n  = tgt;
      mis_n = |redirect_target[1:0];
    end
  end

  assign imem_req     = (state == S_FETCH);
  assign imem_addr    = pc_q;
  assign if_valid     = valid_q;
  assign if_instr     = instr_q;
  assign if_pc        = ipc_q;
  assign if_opcode    = instr_q[6:0];
  assign misalign_err = mis_q;
  assign fetch_count  = cnt_q;

  // read data outside WAIT means memory broke the protocol
  rvalid_only_in_wait: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> state == S_WAIT
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: reset, table vectors, directed
// corner sequences, then random traffic against a protocol model.
module tb_instr_fetch_unit;

  import rv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [6:0]  if_opcode;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .if_valid(if_valid),
    .id_ready(id_ready),
    .if_instr(if_instr),
    .if_pc(if_pc),
    .if_opcode(if_opcode),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .misalign_err(misalign_err),
    .fetch_count(fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h5A5A_A5A5;
  endfunction

  // waits for a request, grants it at once, returns data next cycle
  task automatic do_fetch(input logic [31:0] data,
                          output logic [31:0] gaddr);
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    imem_gnt = 1'b1;
    gaddr    = imem_addr;
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
  endtask

  task automatic handshake();
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] target;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic [6:0]  op;
    logic        mis;
    logic [31:0] nxt;
  } vec_t;

  vec_t tbl[8];

  // random-phase model state
  logic [31:0] m_exp_pc, m_out_pc, m_count, mem_addr;
  logic        m_valid, m_killed, m_mis, mem_busy;
  int          mem_cnt;

  initial begin
    logic [31:0] ga;
    logic [31:0] cnt;
    logic [31:0] hold_instr;
    logic        gnt, rv, rd, hs;
    logic [31:0] tg;

    tbl[0] = '{32'h0000_0040, 32'h0020_81B3, 32'h0000_0040, OP_R,     1'b0, 32'h0000_0044};
    tbl[1] = '{32'h0000_0081, 32'h0000_A283, 32'h0000_0080, OP_LD,    1'b1, 32'h0000_0084};
    tbl[2] = '{32'h0000_0122, 32'h0050_A023, 32'h0000_0120, OP_SD,    1'b1, 32'h0000_0124};
    tbl[3] = '{32'h0000_0203, 32'h0020_8463, 32'h0000_0200, OP_BR,    1'b1, 32'h0000_0204};
    tbl[4] = '{32'h0000_1000, 32'h0080_006F, 32'h0000_1000, OP_JAL,   1'b0, 32'h0000_1004};
    tbl[5] = '{32'hFFFF_FFFC, 32'h0000_8067, 32'hFFFF_FFFC, OP_JALR,  1'b0, 32'h0000_0000};
    tbl[6] = '{32'h0000_07FF, 32'h1234_52B7, 32'h0000_07FC, OP_LUI,   1'b1, 32'h0000_0800};
    tbl[7] = '{32'h0000_0010, 32'h0000_0517, 32'h0000_0010, OP_AUIPC, 1'b0, 32'h0000_0014};

    rst_n           = 1'b0;
    imem_gnt        = 1'b0;
    imem_rvalid     = 1'b0;
    imem_rdata      = 32'hDEAD_BEEF;
    id_ready        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    repeat (2) @(negedge clk);

    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, NOP);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_opcode", {25'd0, if_opcode}, {25'd0, OP_I});
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    rst_n = 1'b1;

    // basic 1-cycle memory fetch
    do_fetch(32'h0050_0093, ga);
    chk("b_gaddr", ga, 32'h0);
    chk("b_valid", {31'd0, if_valid}, 32'd1);
    chk("b_pc", if_pc, 32'h0);
    chk("b_opcode", {25'd0, if_opcode}, {25'd0, OP_I});
    chk("b_instr", if_instr, 32'h0050_0093);
    handshake();
    chk("b_count", fetch_count, 32'd1);
    chk("b_req", {31'd0, imem_req}, 32'd1);
    chk("b_next", imem_addr, 32'h4);
    chk("b_nop", if_instr, NOP);

    // decode stall for five cycles
    do_fetch(32'h00A0_0113, ga);
    chk("s_gaddr", ga, 32'h4);
    for (int i = 0; i < 5; i++) begin
      chk("s_valid", {31'd0, if_valid}, 32'd1);
      chk("s_instr", if_instr, 32'h00A0_0113);
      chk("s_pc", if_pc, 32'h4);
      chk("s_noreq", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
    end
    handshake();
    chk("s_count", fetch_count, 32'd2);
    chk("s_drop", {31'd0, if_valid}, 32'd0);
    @(negedge clk);
    chk("s_once", fetch_count, 32'd2);
    chk("s_next", imem_addr, 32'h8);

    // redirect while grant withheld
    @(negedge clk);
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    do_fetch(32'h0000_0013, ga);
    chk("g_gaddr", ga, 32'h100);
    chk("g_pc", if_pc, 32'h100);
    handshake();

    // redirect in WAIT, stale response later
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt        = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("k_valid", {31'd0, if_valid}, 32'd0);
    chk("k_req", {31'd0, imem_req}, 32'd1);
    chk("k_addr", imem_addr, 32'h200);
    chk("k_count", fetch_count, 32'd3);
    do_fetch(32'h0010_0093, ga);
    chk("k_pc", if_pc, 32'h200);
    handshake();

    // misaligned redirect
    chk("m_pre", {31'd0, misalign_err}, 32'd0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h103;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("m_pulse", {31'd0, misalign_err}, 32'd1);
    chk("m_addr", imem_addr, 32'h100);
    @(negedge clk);
    chk("m_end", {31'd0, misalign_err}, 32'd0);
    do_fetch(32'h0020_0093, ga);
    chk("m_pc", if_pc, 32'h100);
    handshake();

    // table vectors: redirect, fetch, decode
    cnt = 32'd5;
    for (int i = 0; i < 8; i++) begin
      redirect_valid  = 1'b1;
      redirect_target = tbl[i].target;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("t_mis", {31'd0, misalign_err}, {31'd0, tbl[i].mis});
      chk("t_addr", imem_addr, tbl[i].pc);
      do_fetch(tbl[i].rdata, ga);
      chk("t_gaddr", ga, tbl[i].pc);
      chk("t_valid", {31'd0, if_valid}, 32'd1);
      chk("t_pc", if_pc, tbl[i].pc);
      chk("t_instr", if_instr, tbl[i].rdata);
      chk("t_opcode", {25'd0, if_opcode}, {25'd0, tbl[i].op});
      handshake();
      cnt = cnt + 32'd1;
      chk("t_count", fetch_count, cnt);
      chk("t_next", imem_addr, tbl[i].nxt);
      chk("t_nop_op", {25'd0, if_opcode}, {25'd0, OP_I});
    end

    // reset during WAIT with a response arriving inside reset
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt    = 1'b0;
    rst_n       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    @(negedge clk);
    chk("r_valid", {31'd0, if_valid}, 32'd0);
    chk("r_count", fetch_count, 32'd0);
    chk("r_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_fetch(32'h0030_0093, ga);
    chk("r_gaddr", ga, RST_PC);
    chk("r_pc", if_pc, RST_PC);
    chk("r_count0", fetch_count, 32'd0);
    handshake();
    chk("r_count1", fetch_count, 32'd1);

    // random traffic against the protocol model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    m_exp_pc = RST_PC;
    m_out_pc = '0;
    m_count  = '0;
    m_valid  = 1'b0;
    m_killed = 1'b0;
    m_mis    = 1'b0;
    mem_busy = 1'b0;
    mem_addr = '0;
    mem_cnt  = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("x_valid", {31'd0, if_valid}, {31'd0, m_valid});
      if (m_valid) begin
        chk("x_pc", if_pc, m_out_pc);
        chk("x_instr", if_instr, memfn(m_out_pc));
      end else begin
        chk("x_nop", if_instr, NOP);
      end
      chk("x_count", fetch_count, m_count);
      chk("x_mis", {31'd0, misalign_err}, {31'd0, m_mis});
      chk("x_overlap", {31'd0, imem_req & (mem_busy | m_valid)}, 32'd0);
      if (imem_req) chk("x_addr", imem_addr, m_exp_pc);

      rd = ($urandom_range(0, 11) == 0);
      tg = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                        : ($urandom & 32'hFFF);
      id_ready        = $urandom_range(0, 1) == 1;
      gnt             = imem_req && !mem_busy && ($urandom_range(0, 2) != 0);
      rv              = mem_busy && (mem_cnt == 0);
      redirect_valid  = rd;
      redirect_target = tg;
      imem_gnt        = gnt;
      imem_rvalid     = rv;
      imem_rdata      = rv ? memfn(mem_addr) : $urandom;

      m_mis = rd && (tg[1:0] != 2'b00);
      hs    = m_valid && id_ready && !rd;
      if (hs) begin
        m_valid = 1'b0;
        m_count = m_count + 32'd1;
      end
      if (rd) m_valid = 1'b0;
      if (rv) begin
        if (!rd && !m_killed) begin
          m_valid  = 1'b1;
          m_out_pc = mem_addr;
          m_exp_pc = mem_addr + 32'd4;
        end
        m_killed = 1'b0;
      end
      if (rd && (gnt || (mem_busy && !rv))) m_killed = 1'b1;
      if (rd) m_exp_pc = {tg[31:2], 2'b00};

      if (rv) mem_busy = 1'b0;
      if (gnt) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_cnt  = $urandom_range(0, 2);
      end else if (mem_busy && !rv) begin
        mem_cnt = mem_cnt - 1;
      end
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    chk("x_progress", {31'd0, m_count > 32'd100}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
